// File: rtl/spi_arb_pkg.sv
// Shared types and the round-robin pick helper for the SPI receive stream arbiter.
package spi_arb_pkg;

   localparam int N_CH = 4;
   localparam int CH_W = 2;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_e;

   // Returns {found, idx}. The search runs ptr+1, ptr+2, ptr+3, ptr (mod 4).
   // Iterating from the farthest offset down lets the nearest hit overwrite the result.
   function automatic logic [CH_W:0] rr_pick(input logic [N_CH-1:0] req,
                                             input logic [CH_W-1:0] ptr);
      logic [CH_W:0]   res;
      logic [CH_W-1:0] idx;
      res = '0;
      for (int k = N_CH; k >= 1; k--) begin
         idx = ptr + CH_W'(k);
         if (req[idx]) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin selector; no state, the pointer lives in the parent.
module rr_arbiter4
   import spi_arb_pkg::*;
(
   input  logic [N_CH-1:0] req_i,
   input  logic [CH_W-1:0] ptr_i,
   output logic            found_o,
   output logic [CH_W-1:0] idx_o
);

   always_comb begin
      {found_o, idx_o} = rr_pick(req_i, ptr_i);
   end

endmodule

// File: rtl/spi_rx_stream_arbiter.sv
// Packet-granular round-robin mux of four SPI receive streams onto one registered output,
// with a per-packet stall watchdog that closes a dead channel's packet with an abort beat.
//
// state | meaning
// IDLE  | no grant held; pick the next requester round-robin from rr_ptr
// XFER  | cur_chan owns the output until its last beat or a watchdog abort
module spi_rx_stream_arbiter
   import spi_arb_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 1024,
   parameter int TO_W    = 16
) (
   input  logic                     sysclk,
   input  logic                     rst,
   input  logic [N_CH-1:0]          s_valid,
   input  logic [N_CH*DATA_W-1:0]   s_data,
   input  logic [N_CH-1:0]          s_last,
   output logic [N_CH-1:0]          s_ready,
   input  logic [N_CH-1:0]          chan_en,
   output logic                     m_valid,
   output logic [DATA_W-1:0]        m_data,
   output logic                     m_last,
   output logic                     m_abort,
   output logic [CH_W-1:0]          m_chan,
   input  logic                     m_ready,
   output logic                     busy,
   output logic [CH_W-1:0]          cur_chan,
   output logic [N_CH-1:0]          err_sticky,
   input  logic                     err_clr
);

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CH_W-1:0]   cur_chan_q, cur_chan_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic [N_CH-1:0]   err_q, err_d;
   logic              m_valid_q, m_valid_d;
   logic [DATA_W-1:0] m_data_q, m_data_d;
   logic              m_last_q, m_last_d;
   logic              m_abort_q, m_abort_d;
   logic [CH_W-1:0]   m_chan_q, m_chan_d;

   logic [DATA_W-1:0] ch_data [N_CH];
   logic [N_CH-1:0]   req;
   logic [N_CH-1:0]   err_set;
   logic              grant_found;
   logic [CH_W-1:0]   grant_idx;
   logic              out_free;
   logic              in_xfer;
   logic              cur_valid;
   logic              cur_last;
   logic [DATA_W-1:0] cur_data;
   logic              accept;
   logic              stall_tick;
   logic              timeout_hit;

   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         ch_data[i] = s_data[i*DATA_W +: DATA_W];
      end
   end

   assign req = s_valid & chan_en;

   rr_arbiter4 u_rr (
      .req_i   (req),
      .ptr_i   (rr_ptr_q),
      .found_o (grant_found),
      .idx_o   (grant_idx)
   );

   assign out_free    = !m_valid_q || m_ready;
   assign in_xfer     = (state_q == XFER);
   assign cur_valid   = s_valid[cur_chan_q];
   assign cur_last    = s_last[cur_chan_q];
   assign cur_data    = ch_data[cur_chan_q];
   assign accept      = in_xfer && out_free && cur_valid;
   // Back-pressured cycles never advance the watchdog; only a silent source does.
   assign stall_tick  = in_xfer && out_free && !cur_valid;
   assign timeout_hit = stall_tick && (to_cnt_q == TO_LAST);

   always_comb begin
      s_ready = '0;
      if (in_xfer) begin
         s_ready[cur_chan_q] = out_free;
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      cur_chan_d = cur_chan_q;
      to_cnt_d   = to_cnt_q;
      err_set    = '0;
      m_valid_d  = m_valid_q && !m_ready;
      m_data_d   = m_data_q;
      m_last_d   = m_last_q;
      m_abort_d  = m_abort_q;
      m_chan_d   = m_chan_q;

      case (state_q)
         IDLE: begin
            if (grant_found) begin
               cur_chan_d = grant_idx;
               state_d    = XFER;
               to_cnt_d   = '0;
            end
         end
         XFER: begin
            if (accept) begin
               m_valid_d = 1'b1;
               m_data_d  = cur_data;
               m_last_d  = cur_last;
               m_abort_d = 1'b0;
               m_chan_d  = cur_chan_q;
               to_cnt_d  = '0;
               if (cur_last) begin
                  state_d  = IDLE;
                  rr_ptr_d = cur_chan_q;
               end
            end else if (timeout_hit) begin
               m_valid_d           = 1'b1;
               m_data_d            = '0;
               m_last_d            = 1'b1;
               m_abort_d           = 1'b1;
               m_chan_d            = cur_chan_q;
               err_set[cur_chan_q] = 1'b1;
               state_d             = IDLE;
               rr_ptr_d            = cur_chan_q;
               to_cnt_d            = '0;
            end else if (stall_tick) begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A timeout landing on the same cycle as a clear must survive it.
      err_d = (err_clr ? '0 : err_q) | err_set;
   end

   always_ff @(posedge sysclk) begin
      if (rst) begin
         state_q    <= IDLE;
         rr_ptr_q   <= CH_W'(N_CH - 1);
         cur_chan_q <= CH_W'(N_CH - 1);
         to_cnt_q   <= '0;
         err_q      <= '0;
         m_valid_q  <= 1'b0;
         m_data_q   <= '0;
         m_last_q   <= 1'b0;
         m_abort_q  <= 1'b0;
         m_chan_q   <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         cur_chan_q <= cur_chan_d;
         to_cnt_q   <= to_cnt_d;
         err_q      <= err_d;
         m_valid_q  <= m_valid_d;
         m_data_q   <= m_data_d;
         m_last_q   <= m_last_d;
         m_abort_q  <= m_abort_d;
         m_chan_q   <= m_chan_d;
      end
   end

   assign m_valid    = m_valid_q;
   assign m_data     = m_data_q;
   assign m_last     = m_last_q;
   assign m_abort    = m_abort_q;
   assign m_chan     = m_chan_q;
   assign busy       = in_xfer;
   assign cur_chan   = cur_chan_q;
   assign err_sticky = err_q;

endmodule

// File: tb/tb_spi_rx_stream_arbiter.sv
// Self-checking bench: a cycle vector table for the watchdog, a packet-level stream
// scoreboard for ordering/back-pressure/masking, and a reset-mid-packet sequence.
module tb_spi_rx_stream_arbiter;

   localparam int TIMEOUT = 8;

   logic        sysclk = 1'b0;
   logic        rst;
   logic [3:0]  s_valid;
   logic [31:0] s_data;
   logic [3:0]  s_last;
   logic [3:0]  s_ready;
   logic [3:0]  chan_en;
   logic        m_valid;
   logic [7:0]  m_data;
   logic        m_last;
   logic        m_abort;
   logic [1:0]  m_chan;
   logic        m_ready;
   logic        busy;
   logic [1:0]  cur_chan;
   logic [3:0]  err_sticky;
   logic        err_clr;

   always #5 sysclk = ~sysclk;

   spi_rx_stream_arbiter #(.DATA_W(8), .TIMEOUT(TIMEOUT), .TO_W(16)) dut (
      .sysclk(sysclk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
      .s_ready(s_ready), .chan_en(chan_en), .m_valid(m_valid), .m_data(m_data),
      .m_last(m_last), .m_abort(m_abort), .m_chan(m_chan), .m_ready(m_ready),
      .busy(busy), .cur_chan(cur_chan), .err_sticky(err_sticky), .err_clr(err_clr)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      s_valid = '0; s_data = '0; s_last = '0; m_ready = 1'b1; chan_en = 4'hF; err_clr = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge sysclk);
      rst = 1'b1;
      drive_idle();
      @(posedge sysclk);
      @(negedge sysclk);
      rst = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [3:0] sv; logic [7:0] d; logic lst; logic clr;
      logic mv; logic [7:0] md; logic ml; logic ma; logic [1:0] mc;
      logic bz; logic [3:0] sr; logic [1:0] cur; logic [3:0] er;
   } vec_t;
   vec_t tv[$];

   task automatic addv(input logic [3:0] sv, input logic [7:0] d, input logic lst, input logic clr,
                       input logic mv, input logic [7:0] md, input logic ml, input logic ma,
                       input logic [1:0] mc, input logic bz, input logic [3:0] sr,
                       input logic [1:0] cur, input logic [3:0] er);
      vec_t v;
      v.sv = sv; v.d = d; v.lst = lst; v.clr = clr; v.mv = mv; v.md = md; v.ml = ml;
      v.ma = ma; v.mc = mc; v.bz = bz; v.sr = sr; v.cur = cur; v.er = er;
      tv.push_back(v);
   endtask

   task automatic run_table();
      // channel 2: two beats, then silent for TIMEOUT stalled cycles -> abort; channel 3 next
      addv(4'h0, 8'h00, 0, 0,  0, 8'h00, 0, 0, 0,  0, 4'h0, 2'd3, 4'h0);
      addv(4'h4, 8'h21, 0, 0,  0, 8'h00, 0, 0, 0,  0, 4'h0, 2'd3, 4'h0);
      addv(4'h4, 8'h21, 0, 0,  0, 8'h00, 0, 0, 0,  1, 4'h4, 2'd2, 4'h0);
      addv(4'h4, 8'h22, 0, 0,  1, 8'h21, 0, 0, 2,  1, 4'h4, 2'd2, 4'h0);
      addv(4'h0, 8'h00, 0, 0,  1, 8'h22, 0, 0, 2,  1, 4'h4, 2'd2, 4'h0);
      for (int i = 0; i < 5; i++) addv(4'h0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 1, 4'h4, 2'd2, 4'h0);
      addv(4'h8, 8'h31, 1, 0,  0, 8'h00, 0, 0, 0,  1, 4'h4, 2'd2, 4'h0);
      addv(4'h8, 8'h31, 1, 0,  0, 8'h00, 0, 0, 0,  1, 4'h4, 2'd2, 4'h0);
      addv(4'h8, 8'h31, 1, 0,  1, 8'h00, 1, 1, 2,  0, 4'h0, 2'd2, 4'h4);
      addv(4'h8, 8'h31, 1, 0,  0, 8'h00, 0, 0, 0,  1, 4'h8, 2'd3, 4'h4);
      addv(4'h0, 8'h00, 0, 1,  1, 8'h31, 1, 0, 3,  0, 4'h0, 2'd3, 4'h4);
      // variant: channel 2 resumes exactly on the final stalled cycle, so no abort
      addv(4'h4, 8'h41, 0, 0,  0, 8'h00, 0, 0, 0,  0, 4'h0, 2'd3, 4'h0);
      addv(4'h4, 8'h41, 0, 0,  0, 8'h00, 0, 0, 0,  1, 4'h4, 2'd2, 4'h0);
      addv(4'h0, 8'h00, 0, 0,  1, 8'h41, 0, 0, 2,  1, 4'h4, 2'd2, 4'h0);
      for (int i = 0; i < 6; i++) addv(4'h0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 1, 4'h4, 2'd2, 4'h0);
      addv(4'h4, 8'h42, 1, 0,  0, 8'h00, 0, 0, 0,  1, 4'h4, 2'd2, 4'h0);
      addv(4'h0, 8'h00, 0, 0,  1, 8'h42, 1, 0, 2,  0, 4'h0, 2'd2, 4'h0);
      addv(4'h0, 8'h00, 0, 0,  0, 8'h00, 0, 0, 0,  0, 4'h0, 2'd2, 4'h0);

      for (int i = 0; i < tv.size(); i++) begin
         s_valid = tv[i].sv; s_data = {4{tv[i].d}}; s_last = {4{tv[i].lst}};
         err_clr = tv[i].clr; m_ready = 1'b1; chan_en = 4'hF;
         #1;
         chk($sformatf("tv%0d m_valid", i), m_valid, tv[i].mv);
         chk($sformatf("tv%0d busy", i), busy, tv[i].bz);
         chk($sformatf("tv%0d s_ready", i), s_ready, tv[i].sr);
         chk($sformatf("tv%0d cur_chan", i), cur_chan, tv[i].cur);
         chk($sformatf("tv%0d err_sticky", i), err_sticky, tv[i].er);
         if (tv[i].mv) begin
            chk($sformatf("tv%0d m_data", i), m_data, tv[i].md);
            chk($sformatf("tv%0d m_last", i), m_last, tv[i].ml);
            chk($sformatf("tv%0d m_abort", i), m_abort, tv[i].ma);
            chk($sformatf("tv%0d m_chan", i), m_chan, tv[i].mc);
         end
         @(negedge sysclk);
      end
      drive_idle();
   endtask

   // ---------------- stream scoreboard ----------------
   logic [8:0]  srcq [4][$];   // {last, data} beats offered by each source
   logic [10:0] expq [$];      // {chan, last, data} beats expected on the output
   int          st_cyc [4];
   int          bub [4];

   task automatic clear_streams();
      for (int c = 0; c < 4; c++) begin
         srcq[c].delete(); st_cyc[c] = 0; bub[c] = 0;
      end
      expq.delete();
   endtask

   task automatic add_pkt(input int ch, input int len, input logic [7:0] base);
      for (int b = 0; b < len; b++) srcq[ch].push_back({(b == len - 1), 8'(base + b)});
   endtask

   task automatic exp_pkt(input int ch, input int len, input logic [7:0] base);
      for (int b = 0; b < len; b++) expq.push_back({2'(ch), (b == len - 1), 8'(base + b)});
   endtask

   // Every enabled source keeps requesting, so packets emerge in rounds of ascending channel.
   task automatic build_rr(input logic [3:0] mask, input int emit [4]);
      int  rd [4];
      int  cnt [4];
      bit  any;
      for (int c = 0; c < 4; c++) begin rd[c] = 0; cnt[c] = 0; end
      do begin
         any = 0;
         for (int c = 0; c < 4; c++) begin
            if (mask[c] && cnt[c] < emit[c]) begin
               any = 1;
               forever begin
                  expq.push_back({2'(c), srcq[c][rd[c]]});
                  rd[c]++;
                  if (srcq[c][rd[c] - 1][8]) break;
               end
               cnt[c]++;
            end
         end
      end while (any);
   endtask

   task automatic run_stream(input string tag, input logic [3:0] en, input int mr_mode,
                             input bit bubbles, input int en_clr_cyc, input logic [3:0] en_after);
      int         cyc;
      int         idle_after;
      bit         seen_mv;
      bit         prev_stall;
      logic [7:0] pd;
      logic       pl;
      logic [1:0] pc;
      logic [3:0] acc;
      logic [8:0] beat;
      logic [10:0] e;
      logic [3:0] pat;
      pat = 4'b1001;
      cyc = 0; idle_after = 0; seen_mv = 0; prev_stall = 0; pd = '0; pl = 0; pc = '0;
      chan_en = en;
      forever begin
         if (cyc == en_clr_cyc) chan_en = en_after;
         case (mr_mode)
            0: m_ready = 1'b1;
            1: m_ready = ($urandom_range(0, 2) != 0);
            default: m_ready = pat[cyc % 4];
         endcase
         for (int c = 0; c < 4; c++) begin
            s_valid[c] = (cyc >= st_cyc[c]) && (srcq[c].size() > 0) && (bub[c] == 0);
            s_data[c*8 +: 8] = (srcq[c].size() > 0) ? srcq[c][0][7:0] : 8'h00;
            s_last[c] = (srcq[c].size() > 0) ? srcq[c][0][8] : 1'b0;
         end
         #1;
         chk({tag, " s_ready one-hot"}, 32'($onehot0(s_ready)), 32'd1);
         if (prev_stall) begin
            chk({tag, " stall m_valid"}, m_valid, 1'b1);
            chk({tag, " stall m_data"}, m_data, pd);
            chk({tag, " stall m_last"}, m_last, pl);
            chk({tag, " stall m_chan"}, m_chan, pc);
         end
         if (m_valid && !seen_mv) begin
            seen_mv = 1;
            chk({tag, " first m_valid cycle"}, cyc, 2);
         end
         if (m_valid && m_ready) begin
            if (expq.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL %s unexpected beat: chan %0d data %0h, expected none", tag, m_chan, m_data);
            end else begin
               e = expq.pop_front();
               chk({tag, " m_chan"}, m_chan, e[10:9]);
               chk({tag, " m_data"}, m_data, e[7:0]);
               chk({tag, " m_last"}, m_last, e[8]);
               chk({tag, " m_abort"}, m_abort, 1'b0);
            end
         end
         prev_stall = m_valid && !m_ready;
         pd = m_data; pl = m_last; pc = m_chan;
         acc = s_valid & s_ready;
         @(posedge sysclk);
         for (int c = 0; c < 4; c++) begin
            if (bub[c] > 0) bub[c]--;
            if (acc[c]) begin
               beat = srcq[c].pop_front();
               if (bubbles && !beat[8] && $urandom_range(0, 2) == 0) bub[c] = $urandom_range(1, 3);
            end
         end
         cyc++;
         if (expq.size() == 0) idle_after++;
         if (idle_after >= 6) break;
         if (cyc > 3000) begin
            n_checks++; n_fail++;
            $display("FAIL %s cycle budget: %0d beats still outstanding, required 0", tag, expq.size());
            break;
         end
         @(negedge sysclk);
      end
      drive_idle();
   endtask

   initial begin
      int emit [4];
      logic [3:0] mask;
      rst = 1'b1;
      drive_idle();

      do_reset();
      run_table();

      // fairness: 0,1,2,3,0 with 3-beat packets
      do_reset(); clear_streams();
      add_pkt(0, 3, 8'h00); add_pkt(0, 3, 8'h08);
      add_pkt(1, 3, 8'h10); add_pkt(2, 3, 8'h20); add_pkt(3, 3, 8'h30);
      emit = '{2, 1, 1, 1};
      build_rr(4'hF, emit);
      run_stream("fair", 4'hF, 0, 0, -1, 4'hF);

      // lock: channel 1 holds the grant for 5 beats, then 2, then 0
      do_reset(); clear_streams();
      add_pkt(1, 5, 8'h50); add_pkt(0, 2, 8'h60); add_pkt(2, 2, 8'h70);
      st_cyc[0] = 2; st_cyc[2] = 2;
      exp_pkt(1, 5, 8'h50); exp_pkt(2, 2, 8'h70); exp_pkt(0, 2, 8'h60);
      run_stream("lock", 4'hF, 0, 0, -1, 4'hF);

      // back-pressure 1,0,0,1 on a 4-beat packet
      do_reset(); clear_streams();
      add_pkt(0, 4, 8'hA1); exp_pkt(0, 4, 8'hA1);
      run_stream("bp", 4'hF, 2, 0, -1, 4'hF);

      // mask 1010: only 1 and 3, alternating
      do_reset(); clear_streams();
      for (int c = 0; c < 4; c++) begin add_pkt(c, 3, 8'(c * 32)); add_pkt(c, 3, 8'(c * 32 + 16)); end
      emit = '{0, 2, 0, 2};
      build_rr(4'hA, emit);
      run_stream("mask", 4'hA, 0, 0, -1, 4'hA);

      // dropping chan_en[1] mid-packet lets that packet finish, but no new grant to 1
      do_reset(); clear_streams();
      add_pkt(1, 4, 8'hD0); add_pkt(1, 4, 8'hD8); add_pkt(3, 2, 8'hE0);
      exp_pkt(1, 4, 8'hD0); exp_pkt(3, 2, 8'hE0);
      run_stream("en_clr", 4'hA, 0, 0, 3, 4'h8);

      // randomized traffic against the round-robin packet model
      for (int it = 0; it < 6; it++) begin
         do_reset(); clear_streams();
         mask = 4'($urandom_range(1, 15));
         for (int c = 0; c < 4; c++) begin
            int np;
            np = $urandom_range(1, 3);
            for (int p = 0; p < np; p++) add_pkt(c, $urandom_range(1, 4), 8'($urandom));
            emit[c] = np;
         end
         build_rr(mask, emit);
         run_stream($sformatf("rand%0d", it), mask, 1, 1, -1, mask);
      end

      // reset mid-packet, with an error flag and a moved pointer beforehand
      do_reset();
      s_valid = 4'h4; s_data = {4{8'h77}};
      repeat (2) @(negedge sysclk);
      s_valid = 4'h0;
      repeat (12) @(negedge sysclk);
      #1 chk("pre-reset err_sticky", err_sticky, 4'h4);
      s_valid = 4'h1; s_data = {4{8'hB1}}; s_last = 4'h0;
      @(negedge sysclk);
      #1 chk("rst beat1 s_ready", s_ready, 4'h1);
      @(negedge sysclk);
      s_data = {4{8'hB2}}; rst = 1'b1;
      @(negedge sysclk);
      rst = 1'b0; s_valid = 4'h0;
      #1;
      chk("rst m_valid", m_valid, 1'b0);
      chk("rst s_ready", s_ready, 4'h0);
      chk("rst busy", busy, 1'b0);
      chk("rst err_sticky", err_sticky, 4'h0);
      chk("rst cur_chan", cur_chan, 2'd3);
      s_valid = 4'hF; s_data = {4{8'hC0}};
      @(negedge sysclk);
      #1;
      chk("post-rst busy", busy, 1'b1);
      chk("post-rst s_ready", s_ready, 4'h1);
      chk("post-rst cur_chan", cur_chan, 2'd0);
      @(negedge sysclk);
      #1;
      chk("post-rst m_valid", m_valid, 1'b1);
      chk("post-rst m_chan", m_chan, 2'd0);
      chk("post-rst m_data", m_data, 8'hC0);
      drive_idle();
      @(negedge sysclk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_rx_stream_arbiter.md
Name: spi_rx_stream_arbiter

Overview:
Shares one downstream pixel/command stream port, feeding the HDMI frame-buffer writer, among the four SPI slave receiver channels (e, d, c, b mapped to channels 0..3).
- Arbitration is round-robin, granted per packet: a channel keeps the grant until its last beat is accepted.
- A watchdog aborts a granted channel that stalls mid-packet, so one dead SPI link cannot block the others.
- The output is a single registered stage tagged with the source channel.

Parameters:
- DATA_W, 8, width of one beat from each SPI receiver.
- N_CH, 4, number of requesters; the implementation supports only 4.
- CH_W, 2, width of the channel index.
- TIMEOUT, 1024, number of stalled cycles in a granted packet before abort (valid range 2..65535).
- TO_W, 16, width of the watchdog counter.

Ports:
- sysclk, in, 1, the only clock.
- rst, in, 1, synchronous active-high reset.
- s_valid, in, N_CH, per-channel beat valid.
- s_data, in, N_CH*DATA_W, per-channel data; channel i is at [i*DATA_W +: DATA_W].
- s_last, in, N_CH, per-channel end-of-packet flag.
- s_ready, out, N_CH, per-channel accept; one-hot or zero.
- chan_en, in, N_CH, request mask; a masked channel is never newly granted.
- m_valid, out, 1, output beat valid.
- m_data, out, DATA_W, output data.
- m_last, out, 1, output end-of-packet.
- m_abort, out, 1, qualifies an m_last beat produced by a timeout.
- m_chan, out, CH_W, source channel of the output beat.
- m_ready, in, 1, downstream accept.
- busy, out, 1, high while state is XFER.
- cur_chan, out, CH_W, currently or last granted channel.
- err_sticky, out, N_CH, per-channel timeout flags.
- err_clr, in, 1, clears err_sticky.

Behaviour:
- Reset (rst=1 at a sysclk edge):
  - state=IDLE, rr_ptr=3, to_cnt=0, err_sticky=0.
  - Outputs: m_valid=0, m_data=0, m_last=0, m_abort=0, m_chan=0, cur_chan=3, s_ready=0, busy=0.
  - Reset mid-packet drops the packet; nothing further is emitted.
- out_free = !m_valid || m_ready.
- The output register loads only when out_free; it holds otherwise. All AXI-style rules apply: data is stable while valid && !ready.
- IDLE:
  - req = s_valid & chan_en.
  - If req != 0, grant = first set bit searched in order rr_ptr+1, rr_ptr+2, rr_ptr+3, rr_ptr (mod 4).
  - Register grant into cur_chan; state moves to XFER next cycle.
  - s_ready=0 in IDLE.
- XFER:
  - s_ready[cur_chan] = out_free; all other bits are 0. s_ready is combinational from m_valid/m_ready/state.
  - Beat accept = s_valid[cur_chan] && s_ready[cur_chan].
  - On accept: m_data/m_last/m_chan load from the channel, m_abort=0, m_valid=1, to_cnt=0.
  - If that beat has s_last=1: state goes to IDLE and rr_ptr=cur_chan.
  - Latency: s_valid in IDLE at cycle 0 gives s_ready at cycle 1 and m_valid at cycle 2. Streaming in XFER sustains 1 beat/cycle.
- Watchdog (XFER only):
  - When out_free && !s_valid[cur_chan], to_cnt increments. Cycles stalled by downstream back-pressure do not count.
  - When to_cnt reaches TIMEOUT-1 and the increment condition holds:
    - Emit a terminating beat: m_valid=1, m_last=1, m_abort=1, m_data=0, m_chan=cur_chan.
    - Set err_sticky[cur_chan]; state goes to IDLE; rr_ptr=cur_chan; to_cnt=0.
  - If the channel asserts valid in that same cycle, the normal accept takes priority and no abort occurs.
- chan_en:
  - Affects only new grants.
  - Deasserting it for the granted channel mid-packet does not interrupt that packet.
- m_valid drop: when m_ready && no new load, m_valid goes to 0 next cycle.
- err_sticky: err_clr clears it. If err_clr coincides with a new timeout, the set wins for that bit.
- busy = (state==XFER).
- to_cnt does not wrap, because the abort fires at TIMEOUT-1.

Decomposition:
- Package spi_arb_pkg holds:
  - state enum {IDLE, XFER};
  - constant N_CH=4 and CH_W=2;
  - function rr_pick(req, ptr) returning {found, idx}.
- One natural sub-module, rr_arbiter4: combinational 4-way round-robin pick from req and rr_ptr. All registers stay in the top block.

Test Plan:
1. Fairness: all four channels hold valid with 3-beat packets (last on beat 3), chan_en=4'hF, m_ready=1.
   - Packet order on m_chan is 0,1,2,3,0.
   - Exactly 3 beats per packet, m_last only on the 3rd.
   - The first m_valid appears 2 cycles after the first s_valid.
2. Lock: channel 1 sends a 5-beat packet while channel 0 requests from cycle 2.
   - No channel-0 beat appears until channel 1's last beat is accepted.
   - The next grant is 2, skipping nothing invalid, then 0.
3. Back-pressure: m_ready toggles 1,0,0,1 during a 4-beat packet with data 0xA1..0xA4.
   - m_data stays stable while stalled.
   - Output sequence is exactly A1,A2,A3,A4, with no loss or duplication.
4. Timeout with TIMEOUT=8: channel 2 sends 2 beats, then drops valid.
   - After 8 idle cycles: one beat with m_last=1, m_abort=1, m_data=0, m_chan=2.
   - err_sticky=4'b0100; busy falls; channel 3 is granted next.
   - Variant: valid returns on the 8th stalled cycle, so no abort and err_sticky stays 0.
5. Mask: chan_en=4'b1010 with all channels valid.
   - Only channels 1 and 3 are granted, alternating.
   - Clearing chan_en[1] mid-packet still completes that packet.
6. Reset mid-packet: rst is asserted for 1 cycle during beat 2 of channel 0.
   - Next cycle: m_valid=0, s_ready=0, busy=0, err_sticky=0.
   - With all channels then requesting, channel 0 is granted first.
